// File: rtl/hub75_pkg.sv
// hub75_pkg
// Shared constants and types for the HUB75 receive path.
//   DEF_ROWLEN / DEF_ROWS : default pixels per row and rows per panel
//   DEF_ADDR_W / DEF_CNT_W: derived row-address and bit-counter widths
//   rgb_row_t             : one row word {red, green, blue} at default length
//   rx_state_t            : receiver control state (IDLE until first strobe)
package hub75_pkg;

    localparam int unsigned DEF_ROWLEN = 64;
    localparam int unsigned DEF_ROWS   = 16;
    localparam int unsigned DEF_ADDR_W = $clog2(DEF_ROWS);
    localparam int unsigned DEF_CNT_W  = $clog2(DEF_ROWLEN) + 1;

    typedef struct packed {
        logic [DEF_ROWLEN-1:0] red;
        logic [DEF_ROWLEN-1:0] green;
        logic [DEF_ROWLEN-1:0] blue;
    } rgb_row_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } rx_state_t;

endpackage

// File: rtl/hub75_sync.sv
// hub75_sync
// Multi-stage synchronizer for asynchronous HUB75 pins, with optional
// rising-edge detection on the synchronized value.
//   i_clk, i_rst : system clock, async active-high reset
//   i_d          : raw asynchronous inputs (WIDTH bits)
//   o_q          : synchronized inputs, STAGES flops deep
//   o_rise       : one-cycle pulse per bit on a 0->1 of o_q (zero if EDGE_DET=0)
module hub75_sync #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned STAGES   = 2,
    parameter bit          EDGE_DET = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_rise
);

    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_stage[STAGES-1];

    generate
        if (EDGE_DET) begin : g_edge
            logic [WIDTH-1:0] r_hist;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_hist <= '0;
                end else begin
                    r_hist <= o_q;
                end
            end

            assign o_rise = o_q & ~r_hist;
        end else begin : g_no_edge
            assign o_rise = '0;
        end
    endgenerate

endmodule

// File: rtl/hub75_rx.sv
// hub75_rx
// Oversampling HUB75 receiver: rebuilds shifted RGB pixels into row words,
// one word per latch strobe, tagged with the row select.
//   clk, rst                 : system clock, async active-high reset
//   hub_clk, hub_stb, hub_oe : HUB75 shift clock, latch strobe, blanking
//   hub_r, hub_g, hub_b      : serial pixel data
//   hub_sel                  : row select (bit 0 = A)
//   row_valid                : one-cycle pulse with each new row word
//   row_addr                 : row address of the word
//   row_red/green/blue       : row pixels, bit 0 = first pixel shifted
//   frame_start              : row_valid for row 0
//   len_err                  : sticky, a latched row had != ROWLEN bits
//   blank_cycles             : saturating count of blanked cycles last row
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int unsigned ROWLEN      = DEF_ROWLEN,
    parameter int unsigned ROWS        = DEF_ROWS,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hub_clk,
    input  logic                     hub_stb,
    input  logic                     hub_oe,
    input  logic                     hub_r,
    input  logic                     hub_g,
    input  logic                     hub_b,
    input  logic [$clog2(ROWS)-1:0]  hub_sel,
    output logic                     row_valid,
    output logic [$clog2(ROWS)-1:0]  row_addr,
    output logic [ROWLEN-1:0]        row_red,
    output logic [ROWLEN-1:0]        row_green,
    output logic [ROWLEN-1:0]        row_blue,
    output logic                     frame_start,
    output logic                     len_err,
    output logic [15:0]              blank_cycles
);

    localparam int unsigned ADDR_W = $clog2(ROWS);
    localparam int unsigned CNT_W  = $clog2(ROWLEN) + 1;
    localparam int unsigned DATA_W = ADDR_W + 4;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ROWLEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(ROWLEN + 1);

    logic [1:0]        w_edge_q_unused;
    logic [1:0]        w_edge_rise;
    logic [DATA_W-1:0] w_data_q;
    logic [DATA_W-1:0] w_data_rise_unused;

    logic              w_clk_rise;
    logic              w_stb_rise;
    logic              w_r;
    logic              w_g;
    logic              w_b;
    logic              w_oe;
    logic [ADDR_W-1:0] w_sel;

    // Edge pins and data pins share the same pipeline depth, so a data bit
    // arrives in the same cycle as the clock edge that qualifies it.
    hub75_sync #(
        .WIDTH    (2),
        .STAGES   (SYNC_STAGES),
        .EDGE_DET (1'b1)
    ) u_sync_edge (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_d    ({hub_stb, hub_clk}),
        .o_q    (w_edge_q_unused),
        .o_rise (w_edge_rise)
    );

    hub75_sync #(
        .WIDTH    (DATA_W),
        .STAGES   (SYNC_STAGES),
        .EDGE_DET (1'b0)
    ) u_sync_data (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_d    ({hub_sel, hub_oe, hub_b, hub_g, hub_r}),
        .o_q    (w_data_q),
        .o_rise (w_data_rise_unused)
    );

    assign w_clk_rise = w_edge_rise[0];
    assign w_stb_rise = w_edge_rise[1];
    assign {w_sel, w_oe, w_b, w_g, w_r} = w_data_q;

    rx_state_t         r_state;
    logic [ROWLEN-1:0] r_sh_red;
    logic [ROWLEN-1:0] r_sh_green;
    logic [ROWLEN-1:0] r_sh_blue;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [15:0]       r_oe_cnt;

    logic [ROWLEN-1:0] w_red_nxt;
    logic [ROWLEN-1:0] w_green_nxt;
    logic [ROWLEN-1:0] w_blue_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [15:0]       w_oe_nxt;

    // Next-state shift/count values; the latch path uses these so a shift
    // edge coinciding with the strobe lands in the latched word.
    always_comb begin
        w_red_nxt   = r_sh_red;
        w_green_nxt = r_sh_green;
        w_blue_nxt  = r_sh_blue;
        w_cnt_nxt   = r_bit_cnt;
        w_oe_nxt    = r_oe_cnt;
        if (w_clk_rise) begin
            w_red_nxt   = {w_r, r_sh_red[ROWLEN-1:1]};
            w_green_nxt = {w_g, r_sh_green[ROWLEN-1:1]};
            w_blue_nxt  = {w_b, r_sh_blue[ROWLEN-1:1]};
            if (r_bit_cnt != CNT_SAT) begin
                w_cnt_nxt = r_bit_cnt + 1'b1;
            end
        end
        if (w_oe && (r_oe_cnt != '1)) begin
            w_oe_nxt = r_oe_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sh_red     <= '0;
            r_sh_green   <= '0;
            r_sh_blue    <= '0;
            r_bit_cnt    <= '0;
            r_oe_cnt     <= '0;
            row_valid    <= 1'b0;
            frame_start  <= 1'b0;
            row_addr     <= '0;
            row_red      <= '0;
            row_green    <= '0;
            row_blue     <= '0;
            len_err      <= 1'b0;
            blank_cycles <= '0;
        end else begin
            row_valid   <= 1'b0;
            frame_start <= 1'b0;
            r_sh_red    <= w_red_nxt;
            r_sh_green  <= w_green_nxt;
            r_sh_blue   <= w_blue_nxt;
            r_bit_cnt   <= w_cnt_nxt;
            r_oe_cnt    <= w_oe_nxt;
            if (w_stb_rise) begin
                row_red     <= w_red_nxt;
                row_green   <= w_green_nxt;
                row_blue    <= w_blue_nxt;
                row_addr    <= w_sel;
                row_valid   <= 1'b1;
                frame_start <= (w_sel == '0);
                if (w_cnt_nxt != CNT_FULL) begin
                    len_err <= 1'b1;
                end
                r_bit_cnt <= '0;
                r_oe_cnt  <= '0;
                // The period before the first strobe is not a full row.
                if (r_state == ST_RUN) begin
                    blank_cycles <= w_oe_nxt;
                end
                r_state <= ST_RUN;
            end
        end
    end

endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx
// Directed bench for hub75_rx: drives HUB75 pin waveforms (4 clk per bit)
// and compares captured row words against hand-computed constants.
module tb_hub75_rx;

    localparam logic [63:0] PAT_A  = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] PAT_C  = 64'hCCCC_CCCC_CCCC_CCCC;
    localparam logic [63:0] PAT_F0 = 64'hF0F0_F0F0_F0F0_F0F0;
    localparam logic [63:0] PAT_33 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] PAT_3C = 64'h3C3C_3C3C_3C3C_3C3C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hub_clk = 1'b0;
    logic        hub_stb = 1'b0;
    logic        hub_oe = 1'b0;
    logic        hub_r = 1'b0;
    logic        hub_g = 1'b0;
    logic        hub_b = 1'b0;
    logic [3:0]  hub_sel = 4'd0;
    logic        row_valid;
    logic [3:0]  row_addr;
    logic [63:0] row_red;
    logic [63:0] row_green;
    logic [63:0] row_blue;
    logic        frame_start;
    logic        len_err;
    logic [15:0] blank_cycles;

    int checks = 0;
    int failures = 0;
    int n_valid = 0;
    int lat;

    logic [63:0] cap_red;
    logic [63:0] cap_green;
    logic [63:0] cap_blue;
    logic [3:0]  cap_addr;
    logic        cap_frame;
    logic        cap_len;
    logic [15:0] cap_blank;

    hub75_rx #(
        .ROWLEN      (64),
        .ROWS        (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hub_clk      (hub_clk),
        .hub_stb      (hub_stb),
        .hub_oe       (hub_oe),
        .hub_r        (hub_r),
        .hub_g        (hub_g),
        .hub_b        (hub_b),
        .hub_sel      (hub_sel),
        .row_valid    (row_valid),
        .row_addr     (row_addr),
        .row_red      (row_red),
        .row_green    (row_green),
        .row_blue     (row_blue),
        .frame_start  (frame_start),
        .len_err      (len_err),
        .blank_cycles (blank_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (row_valid) n_valid++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic r, input logic g, input logic b);
        hub_clk = 1'b0;
        hub_r = r;
        hub_g = g;
        hub_b = b;
        tick(2);
        hub_clk = 1'b1;
        tick(2);
    endtask

    // Pixel i: red = i[0]; with pat set, green = i[1] and blue = i[2].
    task automatic send_bits(input int n, input bit pat);
        logic [7:0] p;
        for (int i = 0; i < n; i++) begin
            p = 8'(i);
            send_bit(p[0], pat & p[1], pat & p[2]);
        end
    endtask

    // Bounded wait for row_valid; lat = negedges after the strobe pin edge.
    task automatic wait_valid(output int l);
        bit found;
        found = 1'b0;
        l = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (row_valid) begin
                l = k;
                found = 1'b1;
                cap_red   = row_red;
                cap_green = row_green;
                cap_blue  = row_blue;
                cap_addr  = row_addr;
                cap_frame = frame_start;
                cap_len   = len_err;
                cap_blank = blank_cycles;
                break;
            end
        end
        check("row_valid_seen", 64'(found), 64'd1);
    endtask

    task automatic strobe(input logic [3:0] sel, output int l);
        hub_clk = 1'b0;
        hub_sel = sel;
        tick(2);
        hub_stb = 1'b1;
        wait_valid(l);
        tick(2);
        hub_stb = 1'b0;
        tick(2);
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_valid", 64'(row_valid), 64'd0);
        check("rst_addr", 64'(row_addr), 64'd0);
        check("rst_red", row_red, 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        check("rst_blank", 64'(blank_cycles), 64'd0);
        rst = 1'b0;
        tick(2);

        // Full row, red alternating
        send_bits(64, 1'b0);
        strobe(4'd5, lat);
        check("t1_addr", 64'(cap_addr), 64'd5);
        check("t1_red", cap_red, PAT_A);
        check("t1_green", cap_green, 64'd0);
        check("t1_blue", cap_blue, 64'd0);
        check("t1_len_err", 64'(cap_len), 64'd0);
        check("t1_latency", 64'(lat), 64'd3);
        check("t1_pulse_count", 64'(n_valid), 64'd1);

        // Row 15 then row 0: frame_start only with row 0
        send_bits(64, 1'b1);
        strobe(4'd15, lat);
        check("t2_frame_r15", 64'(cap_frame), 64'd0);
        check("t2_green", cap_green, PAT_C);
        check("t2_blue", cap_blue, PAT_F0);
        send_bits(64, 1'b1);
        strobe(4'd0, lat);
        check("t2_frame_r0", 64'(cap_frame), 64'd1);
        check("t2_addr_r0", 64'(cap_addr), 64'd0);

        // 63 bits, then the 64th shift edge together with the strobe edge
        send_bits(63, 1'b1);
        hub_clk = 1'b0;
        hub_sel = 4'd9;
        hub_r = 1'b1;
        hub_g = 1'b1;
        hub_b = 1'b1;
        tick(2);
        hub_clk = 1'b1;
        hub_stb = 1'b1;
        wait_valid(lat);
        tick(2);
        hub_stb = 1'b0;
        hub_clk = 1'b0;
        tick(2);
        check("t3_latency", 64'(lat), 64'd3);
        check("t3_addr", 64'(cap_addr), 64'd9);
        check("t3_red", cap_red, PAT_A);
        check("t3_green", cap_green, PAT_C);
        check("t3_blue", cap_blue, PAT_F0);
        check("t3_len_err", 64'(cap_len), 64'd0);

        // Blanking: oe high 40 clk cycles between two strobes
        hub_oe = 1'b1;
        tick(40);
        hub_oe = 1'b0;
        send_bits(64, 1'b0);
        strobe(4'd7, lat);
        check("t4_blank", 64'(cap_blank), 64'd40);
        check("t4_red", cap_red, PAT_A);

        // Short row sets len_err; overrun keeps last 64 bits, len_err sticky
        send_bits(63, 1'b1);
        strobe(4'd1, lat);
        check("t5_short_len_err", 64'(cap_len), 64'd1);
        send_bits(66, 1'b1);
        strobe(4'd2, lat);
        check("t5_over_red", cap_red, PAT_A);
        check("t5_over_green", cap_green, PAT_33);
        check("t5_over_blue", cap_blue, PAT_3C);
        check("t5_over_len_err", 64'(cap_len), 64'd1);
        // Strobe with no shift edges: new word, shift registers untouched
        strobe(4'd4, lat);
        check("t5_nostb_addr", 64'(cap_addr), 64'd4);
        check("t5_nostb_green", cap_green, PAT_33);
        check("t5_nostb_len_err", 64'(cap_len), 64'd1);

        // Reset mid-row after 30 bits, then a clean row
        send_bits(30, 1'b0);
        hub_clk = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);
        check("t6_rst_len_err", 64'(len_err), 64'd0);
        check("t6_rst_red", row_red, 64'd0);
        check("t6_rst_blank", 64'(blank_cycles), 64'd0);
        rst = 1'b0;
        tick(2);
        send_bits(64, 1'b1);
        strobe(4'd3, lat);
        check("t6_addr", 64'(cap_addr), 64'd3);
        check("t6_red", cap_red, PAT_A);
        check("t6_green", cap_green, PAT_C);
        check("t6_blue", cap_blue, PAT_F0);
        check("t6_len_err", 64'(cap_len), 64'd0);
        tick(3);
        check("total_pulses", 64'(n_valid), 64'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
